// File: rtl/tx_sched_pkg.sv
// Package: tx_sched_pkg
// Shared constants and types for the transmit frame scheduler.
//   HDR_DATA / HDR_CTRL : 2-bit frame headers (idle frames use HDR_CTRL).
//   frame_kind_e        : outcome of one arbitration decision.
package tx_sched_pkg;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  typedef enum logic [1:0] {
    KIND_IDLE,
    KIND_CTRL,
    KIND_DATA
  } frame_kind_e;

endpackage

// File: rtl/tx_frame_sched_if.sv
// Interface: tx_frame_sched_if
// Bundles the requester handshakes and the beat output of tx_frame_sched.
//   data_valid/data_ready/data_payload : user data frame offer
//   ctrl_valid/ctrl_ready/ctrl_payload : control frame offer (payload nonzero)
//   pause                              : remote flow control, gates data only
//   sof_out/data_out                   : beat stream towards the CRC stage
// Modports: master = requesters and beat consumer, slave = scheduler.
interface tx_frame_sched_if #(
  parameter int unsigned PAYLOAD_W = 242,
  parameter int unsigned DWIDTH    = 64
);

  logic                 data_valid;
  logic                 data_ready;
  logic [PAYLOAD_W-1:0] data_payload;
  logic                 ctrl_valid;
  logic                 ctrl_ready;
  logic [PAYLOAD_W-1:0] ctrl_payload;
  logic                 pause;
  logic                 sof_out;
  logic [DWIDTH-1:0]    data_out;

  modport master (
    output data_valid, data_payload, ctrl_valid, ctrl_payload, pause,
    input  data_ready, ctrl_ready, sof_out, data_out
  );

  modport slave (
    input  data_valid, data_payload, ctrl_valid, ctrl_payload, pause,
    output data_ready, ctrl_ready, sof_out, data_out
  );

endinterface

// File: rtl/tx_beat_serializer.sv
// Module: tx_beat_serializer
// Slot counter plus frame-to-beat shift register. A frame presented on
// `frame` is captured in the decision cycle (slot == BEATS-1) and emitted
// MSB beat first over the next BEATS cycles.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   frame     : frame to load in the decision cycle
//   decision  : high in the cycle where the next frame is chosen
//   sof_out   : registered, high on beat 0
//   data_out  : registered beat (top DWIDTH bits of the shift register)
module tx_beat_serializer #(
  parameter int unsigned FRAME_WIDTH = 256,
  parameter int unsigned DWIDTH      = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FRAME_WIDTH-1:0] frame,
  output logic                   decision,
  output logic                   sof_out,
  output logic [DWIDTH-1:0]      data_out
);

  localparam int unsigned BEATS  = FRAME_WIDTH / DWIDTH;
  localparam int unsigned SLOT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(BEATS - 1);

  logic [SLOT_W-1:0]      slot;
  logic [FRAME_WIDTH-1:0] shreg;

  assign decision = (slot == SLOT_LAST);
  // The current beat is the top slice of the shift register itself, so
  // data_out comes straight from flops with no extra output stage.
  assign data_out = shreg[FRAME_WIDTH-1 -: DWIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      slot    <= SLOT_LAST;
      shreg   <= '0;
      sof_out <= 1'b0;
    end else begin
      sof_out <= decision;
      if (decision) begin
        shreg <= frame;
        slot  <= '0;
      end else begin
        shreg <= shreg << DWIDTH;
        slot  <= slot + SLOT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tx_frame_sched.sv
// Module: tx_frame_sched
// Continuous transmit frame scheduler. Each frame slot one of control,
// data or idle is chosen (control over data, data blocked by pause, and a
// forced idle frame every CC_INTERVAL frames), assembled as
// {header, payload, CRC zeros} and streamed as BEATS beats with no gaps.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : tx_frame_sched_if.slave (requester handshakes, beat output)
//   stat_data_frames / stat_ctrl_frames / stat_idle_frames : 32-bit wrapping
//              decision counters, present only with TX_SCHED_STATS_EN defined
module tx_frame_sched
  import tx_sched_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH = 256,
  parameter int unsigned DWIDTH      = 64,
  parameter int unsigned CRC_WIDTH   = 12,
  parameter int unsigned CC_INTERVAL = 1024
) (
  input  logic              clk,
  input  logic              rst,
  tx_frame_sched_if.slave   bus
`ifdef TX_SCHED_STATS_EN
  ,
  output logic [31:0]       stat_data_frames,
  output logic [31:0]       stat_ctrl_frames,
  output logic [31:0]       stat_idle_frames
`endif
);

  localparam int unsigned PAYLOAD_W = FRAME_WIDTH - 2 - CRC_WIDTH;
  localparam int unsigned CC_W      = $clog2(CC_INTERVAL);
  localparam logic [CC_W-1:0] CC_LAST = CC_W'(CC_INTERVAL - 1);

  logic                   decision;
  logic                   forced_idle;
  frame_kind_e            kind;
  logic [CC_W-1:0]        frame_cnt;
  logic [1:0]             hdr;
  logic [PAYLOAD_W-1:0]   payload;
  logic [FRAME_WIDTH-1:0] frame;

  always_comb begin
    forced_idle = (frame_cnt == CC_LAST);
    kind        = KIND_IDLE;
    if (!forced_idle) begin
      if (bus.ctrl_valid)
        kind = KIND_CTRL;
      else if (bus.data_valid && !bus.pause)
        kind = KIND_DATA;
    end
  end

  always_comb begin
    hdr     = HDR_CTRL;
    payload = '0;
    unique case (kind)
      KIND_DATA: begin
        hdr     = HDR_DATA;
        payload = bus.data_payload;
      end
      KIND_CTRL: payload = bus.ctrl_payload;
      default:   payload = '0;
    endcase
    frame = {hdr, payload, {CRC_WIDTH{1'b0}}};
  end

  assign bus.data_ready = !rst && decision && (kind == KIND_DATA);
  assign bus.ctrl_ready = !rst && decision && (kind == KIND_CTRL);

  // Counts every emitted frame; the decision that sees CC_LAST is the
  // forced idle one and restarts the count.
  always_ff @(posedge clk) begin
    if (rst)
      frame_cnt <= '0;
    else if (decision)
      frame_cnt <= forced_idle ? '0 : frame_cnt + CC_W'(1);
  end

`ifdef TX_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_data_frames <= '0;
      stat_ctrl_frames <= '0;
      stat_idle_frames <= '0;
    end else if (decision) begin
      unique case (kind)
        KIND_DATA: stat_data_frames <= stat_data_frames + 32'd1;
        KIND_CTRL: stat_ctrl_frames <= stat_ctrl_frames + 32'd1;
        default:   stat_idle_frames <= stat_idle_frames + 32'd1;
      endcase
    end
  end
`endif

  tx_beat_serializer #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .DWIDTH      (DWIDTH)
  ) u_serializer (
    .clk      (clk),
    .rst      (rst),
    .frame    (frame),
    .decision (decision),
    .sof_out  (bus.sof_out),
    .data_out (bus.data_out)
  );

endmodule

// File: tb/tb_tx_frame_sched.sv
// Testbench: tb_tx_frame_sched
// Drives tx_frame_sched through directed phases (idle, held data, ctrl over
// data, pause, mid-frame reset) and a randomized phase, comparing readies,
// beats, sof and (with TX_SCHED_STATS_EN) stats against a frame-level model.
module tb_tx_frame_sched;

  localparam int FW    = 256;
  localparam int DW    = 64;
  localparam int CRCW  = 12;
  localparam int CC    = 4;
  localparam int PW    = FW - 2 - CRCW;
  localparam int BEATS = FW / DW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  tx_frame_sched_if #(.PAYLOAD_W(PW), .DWIDTH(DW)) bus ();

`ifdef TX_SCHED_STATS_EN
  logic [31:0] s_data, s_ctrl, s_idle;
`endif

  tx_frame_sched #(
    .FRAME_WIDTH (FW),
    .DWIDTH      (DW),
    .CRC_WIDTH   (CRCW),
    .CC_INTERVAL (CC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef TX_SCHED_STATS_EN
    ,
    .stat_data_frames (s_data),
    .stat_ctrl_frames (s_ctrl),
    .stat_idle_frames (s_idle)
`endif
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model state: cycles since reset release, decisions since reset,
  // queue of expected beats, decision tallies.
  int unsigned     t   = 0;
  int unsigned     nfr = 0;
  logic [DW-1:0]   expq[$];
  bit              sofq[$];
  int unsigned     m_data = 0, m_ctrl = 0, m_idle = 0;

  // Stimulus state.
  logic            dv = 1'b0, cv = 1'b0, pz = 1'b0;
  logic [PW-1:0]   dp = '0, cp = '0;
  bit              acc_d = 1'b0, acc_c = 1'b0;

  function automatic logic [PW-1:0] rand_payload();
    logic [255:0] tmp;
    for (int i = 0; i < 8; i++) tmp[i*32 +: 32] = $urandom;
    return tmp[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] rand_ctrl();
    logic [PW-1:0] v;
    v = rand_payload();
    if (v == '0) v = 1;
    return v;
  endfunction

  task automatic step(input logic r);
    logic [FW-1:0] f;
    int            kind;   // 0 idle, 1 ctrl, 2 data
    logic          exp_dr, exp_cr;
    logic [DW-1:0] eb;
    bit            es;
    @(negedge clk);
    rst              = r;
    bus.data_valid   = dv;
    bus.data_payload = dp;
    bus.ctrl_valid   = cv;
    bus.ctrl_payload = cp;
    bus.pause        = pz;
    #1;
    exp_dr = 1'b0;
    exp_cr = 1'b0;
    if (!r && (t % BEATS == 0)) begin
      if (nfr % CC == CC - 1)  kind = 0;
      else if (cv)             kind = 1;
      else if (dv && !pz)      kind = 2;
      else                     kind = 0;
      nfr++;
      f = '0;
      if (kind == 2) begin
        f[FW-1:FW-2] = 2'b01;
        f[FW-3:CRCW] = dp;
        exp_dr = 1'b1;
        m_data++;
      end else begin
        f[FW-1:FW-2] = 2'b10;
        if (kind == 1) begin
          f[FW-3:CRCW] = cp;
          exp_cr = 1'b1;
          m_ctrl++;
        end else begin
          m_idle++;
        end
      end
      for (int k = 0; k < BEATS; k++) begin
        expq.push_back(DW'(f >> (FW - (k + 1) * DW)));
        sofq.push_back(k == 0);
      end
    end
    if (!r) t++;
    check("data_ready", 64'(bus.data_ready), 64'(exp_dr));
    check("ctrl_ready", 64'(bus.ctrl_ready), 64'(exp_cr));
    acc_d = exp_dr;
    acc_c = exp_cr;
    @(posedge clk);
    #1;
    if (r) begin
      t = 0; nfr = 0;
      expq.delete(); sofq.delete();
      m_data = 0; m_ctrl = 0; m_idle = 0;
      es = 1'b0; eb = '0;
    end else if (expq.size() == 0) begin
      es = 1'b1; eb = '1;   // nothing scheduled: forces a visible failure
    end else begin
      eb = expq.pop_front();
      es = sofq.pop_front();
    end
    check("sof_out", 64'(bus.sof_out), 64'(es));
    check("data_out", 64'(bus.data_out), 64'(eb));
`ifdef TX_SCHED_STATS_EN
    check("stat_data", 64'(s_data), 64'(m_data));
    check("stat_ctrl", 64'(s_ctrl), 64'(m_ctrl));
    check("stat_idle", 64'(s_idle), 64'(m_idle));
`endif
  endtask

  task automatic pick_random();
    if (!dv || acc_d) begin
      dv = ($urandom_range(0, 2) != 0);
      dp = rand_payload();
    end
    if (!cv || acc_c) begin
      cv = ($urandom_range(0, 3) == 0);
      cp = rand_ctrl();
    end
    pz = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    repeat (3) step(1'b1);

    // No requests: idle frames only.
    repeat (12) step(1'b0);

    // Data held with all-ones payload, including forced idle slots.
    dv = 1'b1; dp = '1;
    repeat (24) step(1'b0);

    // Control and data both held: control wins until it drops.
    cv = 1'b1; cp = rand_ctrl();
    repeat (16) step(1'b0);
    cv = 1'b0;
    repeat (8) step(1'b0);

    // Pause blocks data; release it mid-frame.
    pz = 1'b1;
    repeat (12) step(1'b0);
    while (t % BEATS != 2) step(1'b0);
    pz = 1'b0;
    repeat (8) step(1'b0);

    // Randomized traffic with occasional resets.
    repeat (600) begin
      pick_random();
      step($urandom_range(0, 79) == 0);
    end

    // Reset asserted at slot 2 with data offered.
    dv = 1'b1; cv = 1'b0; pz = 1'b0; dp = rand_payload();
    step(1'b0);
    while (t % BEATS != 3) step(1'b0);
    step(1'b1);
    repeat (10) step(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_frame_sched.md
TX_FRAME_SCHED -- requirements
Module: tx_frame_sched

Interface
REQ-001 Parameter FRAME_WIDTH, default 256: frame size in bits; SHALL be an integer multiple of DWIDTH.
REQ-002 Parameter DWIDTH, default 64: beat width in bits.
REQ-003 Parameter CRC_WIDTH, default 12: low frame bits reserved for the downstream CRC; SHALL be less than DWIDTH.
REQ-004 Parameter CC_INTERVAL, default 1024: frames between forced idle frames; SHALL be at least 2.
REQ-005 Derived PAYLOAD_W = FRAME_WIDTH-2-CRC_WIDTH; BEATS = FRAME_WIDTH/DWIDTH.
REQ-006 Ports SHALL be:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- data_valid  in  1  user data frame offered.
- data_ready  out  1  data frame accepted this cycle.
- data_payload  in  PAYLOAD_W  user payload.
- ctrl_valid  in  1  control frame offered.
- ctrl_ready  out  1  control frame accepted this cycle.
- ctrl_payload  in  PAYLOAD_W  control code; nonzero.
- pause  in  1  remote flow control; blocks data frames only.
- sof_out  out  1  first beat of a frame.
- data_out  out  DWIDTH  beat to the CRC/frame-ID stage.

Function
REQ-007 Output SHALL be continuous: one beat per cycle, sof_out every BEATS cycles, no gaps.
REQ-008 Frame layout: bits [FRAME_WIDTH-1:FRAME_WIDTH-2] header; [FRAME_WIDTH-3:CRC_WIDTH] payload; [CRC_WIDTH-1:0] zero.
REQ-009 Beat k of a frame (k=0 first) SHALL be frame[FRAME_WIDTH-1-k*DWIDTH -: DWIDTH].
REQ-010 Headers: data frame 2'b01; control and idle frames 2'b10. Idle payload is all zeros.
REQ-011 A slot counter SHALL run 0..BEATS-1 and wrap. Arbitration happens only in the cycle where the counter is BEATS-1 (the decision cycle).
REQ-012 Decision priority SHALL be:
- forced idle (REQ-014);
- then ctrl_valid;
- then data_valid with pause low;
- else idle.
REQ-013 ctrl_ready or data_ready SHALL assert for exactly the decision cycle of the chosen requester; both SHALL be low otherwise and during rst.
REQ-014 A frame counter SHALL count emitted frames. When it reaches CC_INTERVAL-1, the next decision SHALL be forced idle and the counter SHALL reset to 0.
REQ-015 The frame chosen in the decision cycle SHALL have its beat 0 on data_out, with sof_out=1, in the following cycle.
REQ-016 data_out and sof_out SHALL be driven directly from registers.
REQ-017 With BEATS=1, every cycle SHALL be a decision cycle and sof_out SHALL be held at 1.
REQ-018 pause SHALL be sampled only in the decision cycle. A pause that asserts mid-frame does not truncate the frame in flight.
REQ-019 Requesters SHALL hold valid and payload stable until ready. The block does not buffer offers that are not accepted.

Reset
REQ-020 During rst the block SHALL hold:
- sof_out=0, data_out=0;
- data_ready=0, ctrl_ready=0;
- slot counter = BEATS-1;
- frame counter = 0.
REQ-021 The first cycle after rst deasserts SHALL be a decision cycle.
REQ-022 rst asserted mid-frame SHALL abandon the frame immediately. No partial beats SHALL follow.

Configuration
REQ-023 With TX_SCHED_STATS_EN defined, three 32-bit wrapping outputs SHALL exist: stat_data_frames, stat_ctrl_frames, stat_idle_frames.
REQ-024 Each stat counter SHALL increment once per decision of its kind and clear on rst.
REQ-025 Without TX_SCHED_STATS_EN, these ports and counters SHALL be absent. All other behaviour SHALL be identical.

Structure
REQ-026 Package tx_sched_pkg SHALL hold:
- header constants HDR_DATA=2'b01 and HDR_CTRL=2'b10;
- enum frame_kind_e {KIND_IDLE, KIND_CTRL, KIND_DATA}.
REQ-027 The frame-to-beat shift register and slot counter SHALL form sub-module tx_beat_serializer. Arbitration, the CC counter and the stats stay in tx_frame_sched.

Verification
(Defaults unless stated; PAYLOAD_W=242, BEATS=4.)
REQ-028 Release rst with no requests -> sof_out at cycles 1, 5, 9…; beat 0 = 64'h8000_0000_0000_0000; beats 1-3 = 0.
REQ-029 data_valid held, data_payload all ones -> data_ready pulses every 4 cycles:
- beat 0 = 64'h7FFF_FFFF_FFFF_FFFF;
- beat 3 = 64'hFFFF_FFFF_FFFF_F000.
REQ-030 ctrl_valid and data_valid both held -> only ctrl_ready pulses; data_ready stays 0 until ctrl_valid drops.
REQ-031 pause=1 with data_valid held -> idle frames only; pause dropping mid-frame -> data accepted at the next decision cycle.
REQ-032 CC_INTERVAL=4, data_valid held -> every 4th frame is idle; data_ready misses that decision.
REQ-033 rst pulsed at slot 2, then stats read (with TX_SCHED_STATS_EN) -> outputs zero during rst, decision in the first cycle after, all stats 0.
